soc_interface_wb_master: RTL
============================

// Module: soc_interface_wb_master
// PURPOSE
//  Host-side initiator of the SoC byte-stream protocol: Wishbone slave in, AXI-stream bytes out/in.
//  Turns each classic WB cycle into one command frame and parses the response frame.
//  Sits in front of the serial/USB byte link driving the remote WB-bridging responder.
// PARAMETERS
//  TIMEOUT_CYCLES  65535  read-response timeout in clk cycles (used only with SOC_IF_TIMEOUT_EN)
// PORTS
//  clk                 in   1   clock; single clock domain
//  rst                 in   1   asynchronous, active-high reset
//  output_axis_tdata   out  8   command/address/write bytes to link
//  output_axis_tvalid  out  1
//  output_axis_tready  in   1
//  output_axis_tlast   out  1   end of command frame
//  input_axis_tdata    in   8   response bytes from link
//  input_axis_tvalid   in   1
//  input_axis_tready   out  1
//  input_axis_tlast    in   1
//  wb_adr_i            in   36  byte address; [1:0] ignored (word-aligned)
//  wb_dat_i            in   32  write data
//  wb_dat_o            out  32  read data, valid with wb_ack_o
//  wb_we_i             in   1
//  wb_sel_i            in   4
//  wb_stb_i            in   1
//  wb_cyc_i            in   1
//  wb_ack_o            out  1   one-cycle pulse
//  wb_err_o            out  1   one-cycle pulse
//  busy                out  1   high whenever state != IDLE (registered)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-frame aborts silently (no tlast sent).
//  Outputs registered; a byte moves on tvalid&tready; next byte may load in the same cycle.
//  IDLE: on cyc&stb&!ack&!err latch adr/dat/we/sel -> CMD.
//  CMD: send {we?4'hB:4'hA, adr[35:32]} -> ADDR. Address bytes MSB first: adr[31:24],[23:16],[15:8],
//   then {adr[7:2], off}; off = 0 for reads, index of lowest set sel bit for writes.
//  Writes: sel must be contiguous and nonzero; otherwise no frame, wb_err_o pulses from IDLE (2 cycles).
//   WR_DATA sends dat lanes off..hi (hi = highest set sel bit), LSB lane first, tlast on lane hi
//   -> ACK once the tlast byte is accepted. No response frame is expected for writes.
//  Reads: after last addr byte (tlast=0), tvalid stays low; input_axis_tready=1.
//   RD_FLAG: discard bytes until 0x01 -> RD_DATA: capture 4 bytes into wb_dat_o[7:0]..[31:24].
//   RD_END: send single 0x00 with tlast=1 -> DRAIN: accept/discard input until a byte with tlast
//   (covers prefetched extra bytes and closing 0x00) -> ACK.
//  Input tlast seen in RD_FLAG/RD_DATA (early end): goto RD_END, then DRAIN to the next tlast.
//   Return wb_err_o instead of ack.
//  ACK: pulse wb_ack_o (or wb_err_o) one cycle -> IDLE; master must drop stb before the next cycle.
//  input_axis_tready is 0 in IDLE/CMD/ADDR/WR_DATA; stray input bytes there stay stalled.
// CONFIGURATION
//  SOC_IF_TIMEOUT_EN defined: 16-bit counter runs in RD_FLAG/RD_DATA and resets on each accepted byte.
//   At TIMEOUT_CYCLES -> RD_END, DRAIN, then wb_err_o.
//  Undefined: reads wait indefinitely; no counter is synthesized.
// STRUCTURE
//  Shared header soc_interface_defs.vh: CMD_READ=4'hA, CMD_WRITE=4'hB, START_FLAG=8'h01,
//   END_BYTE=8'h00; used by both the responder and this block.
//  State encoding is a local 4-bit localparam set. No sub-module: one next-state always block
//   plus one async-reset register block.
// TESTING
//  Read adr=36'h3_1234_5678 -> out A3 12 34 56 78; in 01 EF BE AD DE, 00(tlast) -> dat_o=DEADBEEF, ack.
//  Write adr=0_0000_0010 sel=1111 dat=11223344 -> out B0 00 00 00 10 44 33 22 11(tlast), ack.
//  Write sel=0110 dat=AABBCCDD -> addr lsb byte 0x11, data CC BB(tlast), ack; sel=0101 -> err, no bytes.
//  Read with 3 extra prefetched bytes before 00(tlast) -> all drained, ack; next read frames correctly.
//  Read where input tlast arrives after 2 data bytes -> 00(tlast) sent, err pulse, back to IDLE.
//  SOC_IF_TIMEOUT_EN, TIMEOUT_CYCLES=16, no response -> err at 16 cycles; output_axis_tready=0
//   throughout -> no progress, busy stays high.

Source files
------------

// File: rtl/soc_interface_wb_master_pkg.sv
// soc_interface_wb_master_pkg: frame constants, FSM state type and byte-select
// helpers shared by the WB-to-byte-stream initiator.
package soc_interface_wb_master_pkg;

  // Frame constants understood by the remote WB-bridging responder.
  localparam logic [3:0] CMD_READ   = 4'hA;
  localparam logic [3:0] CMD_WRITE  = 4'hB;
  localparam logic [7:0] START_FLAG = 8'h01;
  localparam logic [7:0] END_BYTE   = 8'h00;

  // Initiator states; 4-bit encoding so the value can be probed directly.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CMD     = 4'd1,
    ST_ADDR    = 4'd2,
    ST_WR_DATA = 4'd3,
    ST_RD_FLAG = 4'd4,
    ST_RD_DATA = 4'd5,
    ST_RD_END  = 4'd6,
    ST_DRAIN   = 4'd7,
    ST_ACK     = 4'd8
  } state_t;

  // Index of the lowest set byte-select bit (3 when none is set).
  function automatic logic [1:0] sel_lo(input logic [3:0] sel);
    if (sel[0])      return 2'd0;
    else if (sel[1]) return 2'd1;
    else if (sel[2]) return 2'd2;
    else             return 2'd3;
  endfunction

  // Index of the highest set byte-select bit (0 when none is set).
  function automatic logic [1:0] sel_hi(input logic [3:0] sel);
    if (sel[3])      return 2'd3;
    else if (sel[2]) return 2'd2;
    else if (sel[1]) return 2'd1;
    else             return 2'd0;
  endfunction

  // A write is framable only if its byte selects form one nonzero run.
  // After shifting the run down to bit 0 it must look like 2^n-1.
  function automatic logic sel_ok(input logic [3:0] sel);
    logic [3:0] m;
    m = sel >> sel_lo(sel);
    return (sel != 4'd0) && ((m & (m + 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/soc_interface_wb_master_if.sv
// soc_interface_wb_master_if: bundles the Wishbone slave port and the two
// AXI-stream byte links of the initiator. The master modport is the
// initiator's view; the slave modport is the view of whatever surrounds it.
//
// Handshake rules: a byte on either stream moves on a rising edge where
// tvalid and tready are both high. Once tvalid is raised, tdata/tlast hold
// until that edge. On the Wishbone side a request is cyc&stb; it completes
// with a single-cycle ack or err pulse and the requester drops stb before
// starting another cycle.
interface soc_interface_wb_master_if;
  import soc_interface_wb_master_pkg::*;

  logic [7:0]  output_axis_tdata;
  logic        output_axis_tvalid;
  logic        output_axis_tready;
  logic        output_axis_tlast;
  logic [7:0]  input_axis_tdata;
  logic        input_axis_tvalid;
  logic        input_axis_tready;
  logic        input_axis_tlast;
  logic [35:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        busy;
  state_t      dbg_state;

  modport master (
    output output_axis_tdata, output_axis_tvalid, output_axis_tlast,
    input  output_axis_tready,
    input  input_axis_tdata, input_axis_tvalid, input_axis_tlast,
    output input_axis_tready,
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output busy, dbg_state
  );

  modport slave (
    input  output_axis_tdata, output_axis_tvalid, output_axis_tlast,
    output output_axis_tready,
    output input_axis_tdata, input_axis_tvalid, input_axis_tlast,
    input  input_axis_tready,
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    input  busy, dbg_state
  );

endinterface

// File: rtl/soc_interface_wb_master.sv
// soc_interface_wb_master: turns each classic Wishbone cycle into one command
// frame on the outgoing byte stream and, for reads, parses the response frame
// from the incoming byte stream.
// Optional feature: define SOC_IF_TIMEOUT_EN to abort reads whose response
// stalls for TIMEOUT_CYCLES clocks; without it reads wait indefinitely.
module soc_interface_wb_master
  import soc_interface_wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  soc_interface_wb_master_if.master  bus
);

  state_t      state;
  logic [35:2] adr_q;
  logic [31:0] dat_q;
  logic        we_q;
  logic [1:0]  off_q;
  logic [1:0]  hi_q;
  logic [1:0]  lane_q;
  logic [2:0]  cnt_q;
  logic        err_q;

  logic [7:0]  out_data_q;
  logic        out_valid_q;
  logic        out_last_q;
  logic        in_ready_q;
  logic [31:0] rd_dat_q;
  logic        ack_q;
  logic        err_pulse_q;
  logic        busy_q;

  logic        out_fire;
  logic        in_fire;
  logic        wb_req;
  logic [1:0]  lane_nx;
  logic [7:0]  addr_byte;

`ifdef SOC_IF_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        to_hit;
  assign to_hit = (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`endif

  assign out_fire = out_valid_q && bus.output_axis_tready;
  assign in_fire  = in_ready_q && bus.input_axis_tvalid;
  // A request is only taken when no completion pulse is on the bus, so the
  // cycle that is being acknowledged is never re-accepted.
  assign wb_req   = bus.wb_cyc_i && bus.wb_stb_i && !ack_q && !err_pulse_q;
  assign lane_nx  = lane_q + 2'd1;

  // Address byte to load next: three full bytes MSB first, then the word
  // address bits with the starting lane offset in the two low bits.
  always_comb begin
    addr_byte = 8'h00;
    case (cnt_q[1:0])
      2'd0:    addr_byte = adr_q[31:24];
      2'd1:    addr_byte = adr_q[23:16];
      2'd2:    addr_byte = adr_q[15:8];
      default: addr_byte = {adr_q[7:2], off_q};
    endcase
  end

  // Frame sequencer: all bus outputs are registered here; the next outgoing
  // byte loads in the same cycle the current one is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      off_q       <= 2'd0;
      hi_q        <= 2'd0;
      lane_q      <= 2'd0;
      cnt_q       <= 3'd0;
      err_q       <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      rd_dat_q    <= '0;
      ack_q       <= 1'b0;
      err_pulse_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SOC_IF_TIMEOUT_EN
      to_cnt_q    <= 16'd0;
`endif
    end else begin
      ack_q       <= 1'b0;
      err_pulse_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wb_req) begin
            adr_q  <= bus.wb_adr_i[35:2];
            dat_q  <= bus.wb_dat_i;
            we_q   <= bus.wb_we_i;
            off_q  <= bus.wb_we_i ? sel_lo(bus.wb_sel_i) : 2'd0;
            hi_q   <= sel_hi(bus.wb_sel_i);
            busy_q <= 1'b1;
            if (bus.wb_we_i && !sel_ok(bus.wb_sel_i)) begin
              // Unframable byte selects: no bytes leave, just an error.
              err_q <= 1'b1;
              state <= ST_ACK;
            end else begin
              err_q <= 1'b0;
              state <= ST_CMD;
            end
          end
        end
        ST_CMD: begin
          out_valid_q <= 1'b1;
          out_data_q  <= {(we_q ? CMD_WRITE : CMD_READ), adr_q[35:32]};
          out_last_q  <= 1'b0;
          cnt_q       <= 3'd0;
          state       <= ST_ADDR;
        end
        ST_ADDR: begin
          if (out_fire) begin
            if (cnt_q != 3'd4) begin
              out_data_q <= addr_byte;
              cnt_q      <= cnt_q + 3'd1;
            end else if (we_q) begin
              out_data_q <= dat_q[{off_q, 3'b000} +: 8];
              out_last_q <= (off_q == hi_q);
              lane_q     <= off_q;
              state      <= ST_WR_DATA;
            end else begin
              // Read command ends without tlast; the response comes next.
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              cnt_q       <= 3'd0;
              state       <= ST_RD_FLAG;
`ifdef SOC_IF_TIMEOUT_EN
              to_cnt_q    <= 16'd0;
`endif
            end
          end
        end
        ST_WR_DATA: begin
          if (out_fire) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state       <= ST_ACK;
            end else begin
              lane_q     <= lane_nx;
              out_data_q <= dat_q[{lane_nx, 3'b000} +: 8];
              out_last_q <= (lane_nx == hi_q);
            end
          end
        end
        ST_RD_FLAG: begin
          if (in_fire) begin
`ifdef SOC_IF_TIMEOUT_EN
            to_cnt_q <= 16'd0;
`endif
            if (bus.input_axis_tlast) begin
              err_q       <= 1'b1;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= END_BYTE;
              out_last_q  <= 1'b1;
              state       <= ST_RD_END;
            end else if (bus.input_axis_tdata == START_FLAG) begin
              cnt_q <= 3'd0;
              state <= ST_RD_DATA;
            end
`ifdef SOC_IF_TIMEOUT_EN
          end else if (to_hit) begin
            err_q       <= 1'b1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= END_BYTE;
            out_last_q  <= 1'b1;
            state       <= ST_RD_END;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
`endif
          end
        end
        ST_RD_DATA: begin
          if (in_fire) begin
`ifdef SOC_IF_TIMEOUT_EN
            to_cnt_q <= 16'd0;
`endif
            if (bus.input_axis_tlast) begin
              err_q       <= 1'b1;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= END_BYTE;
              out_last_q  <= 1'b1;
              state       <= ST_RD_END;
            end else begin
              rd_dat_q[{cnt_q[1:0], 3'b000} +: 8] <= bus.input_axis_tdata;
              if (cnt_q == 3'd3) begin
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b1;
                out_data_q  <= END_BYTE;
                out_last_q  <= 1'b1;
                state       <= ST_RD_END;
              end else begin
                cnt_q <= cnt_q + 3'd1;
              end
            end
`ifdef SOC_IF_TIMEOUT_EN
          end else if (to_hit) begin
            err_q       <= 1'b1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= END_BYTE;
            out_last_q  <= 1'b1;
            state       <= ST_RD_END;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
`endif
          end
        end
        ST_RD_END: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Prefetched bytes and the closing byte are swallowed up to tlast.
          if (in_fire && bus.input_axis_tlast) begin
            in_ready_q <= 1'b0;
            state      <= ST_ACK;
          end
        end
        ST_ACK: begin
          ack_q       <= !err_q;
          err_pulse_q <= err_q;
          busy_q      <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.output_axis_tdata  = out_data_q;
  assign bus.output_axis_tvalid = out_valid_q;
  assign bus.output_axis_tlast  = out_last_q;
  assign bus.input_axis_tready  = in_ready_q;
  assign bus.wb_dat_o           = rd_dat_q;
  assign bus.wb_ack_o           = ack_q;
  assign bus.wb_err_o           = err_pulse_q;
  assign bus.busy               = busy_q;
  assign bus.dbg_state          = state;

endmodule
